// File: rtl/signed_addsub_seq.sv
`default_nettype none
// ============================================================================
//  Module      : signed_addsub_seq
//  Description : Multi-cycle signed two's-complement adder/subtractor.
//                WIDTH-bit operands are summed CHUNK bits per clock through a
//                single narrow adder slice, with the carry rippled between
//                cycles. Valid/ready handshakes on the input and output
//                sides. Reports overflow, negative and zero flags.
//                Optional macro SIGNED_ADDSUB_SAT_EN clamps the result on
//                signed overflow instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module signed_addsub_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s_res,
    output logic             ovf,
    output logic             neg,
    output logic             zero
);

    localparam int NCH  = WIDTH / CHUNK;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NCH - 1);
`ifdef SIGNED_ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] C_MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] C_MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;           // b already inverted for subtract
    logic              carry_q, carry_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              ovf_q, ovf_d;
    logic              neg_q, neg_d;
    logic              zero_q, zero_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    logic [CHUNK-1:0]  w_a_chunk;
    logic [CHUNK-1:0]  w_b_chunk;
    logic [CHUNK:0]    w_chunk_sum;
    logic [WIDTH-1:0]  w_raw;
    logic              w_ovf;

    // State register and all registered outputs; reset abandons any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            res_q       <= '0;
            ovf_q       <= 1'b0;
            neg_q       <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            res_q       <= res_d;
            ovf_q       <= ovf_d;
            neg_q       <= neg_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Chunk adder slice, next-state logic and next values of the outputs.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
        res_d     = res_q;
        ovf_d     = ovf_q;
        neg_d     = neg_q;
        zero_d    = zero_q;

        // One CHUNK-wide slice, fed by the chunk currently selected.
        w_a_chunk   = a_q[idx_q*CHUNK +: CHUNK];
        w_b_chunk   = b_q[idx_q*CHUNK +: CHUNK];
        w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, carry_q};

        // Partial result with this cycle's chunk merged in; complete on the last chunk.
        w_raw = res_q;
        w_raw[idx_q*CHUNK +: CHUNK] = w_chunk_sum[CHUNK-1:0];

        // Same-sign operands producing a different-sign sum means overflow.
        w_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (w_raw[WIDTH-1] != a_q[WIDTH-1]);

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d     = num1;
                    b_d     = op_sub ? ~num2 : num2;
                    carry_d = op_sub;
                    idx_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                res_d   = w_raw;
                carry_d = w_chunk_sum[CHUNK];
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == C_LAST_IDX) begin
                    ovf_d = w_ovf;
`ifdef SIGNED_ADDSUB_SAT_EN
                    if (w_ovf) begin
                        res_d = a_q[WIDTH-1] ? C_MIN_NEG : C_MAX_POS;
                    end
`endif
                    neg_d   = res_d[WIDTH-1];
                    zero_d  = (res_d == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready && out_valid_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake flags follow the state being entered so they are registered.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign s_res     = res_q;
    assign ovf       = ovf_q;
    assign neg       = neg_q;
    assign zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_signed_addsub_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_signed_addsub_seq
//  Description : Self-checking bench for signed_addsub_seq (WIDTH=32,
//                CHUNK=8). Directed cases plus randomized operations checked
//                against an arithmetic reference model. Honours the
//                SIGNED_ADDSUB_SAT_EN macro.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_signed_addsub_seq;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int NCH   = WIDTH / CHUNK;
    localparam longint C_MAXP = 64'sh7FFF_FFFF;
    localparam longint C_MINN = -64'sh8000_0000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             op_sub = 1'b0;
    logic [WIDTH-1:0] num1 = '0;
    logic [WIDTH-1:0] num2 = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] s_res;
    logic             ovf;
    logic             neg;
    logic             zero;

    int checks = 0;
    int errors = 0;

    signed_addsub_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .num1      (num1),
        .num2      (num2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s_res     (s_res),
        .ovf       (ovf),
        .neg       (neg),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer arithmetic, then wrap or clamp to 32 bits.
    task automatic model(input logic [31:0] x, input logic [31:0] y, input bit s,
                         output logic [31:0] r, output bit o);
        longint lx, ly, m;
        lx = longint'($signed(x));
        ly = longint'($signed(y));
        m  = s ? (lx - ly) : (lx + ly);
        o  = (m > C_MAXP) || (m < C_MINN);
        r  = m[31:0];
`ifdef SIGNED_ADDSUB_SAT_EN
        if (m > C_MAXP) r = 32'h7FFF_FFFF;
        if (m < C_MINN) r = 32'h8000_0000;
`endif
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'(int'($urandom_range(0, 20)) - 10);
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Full transaction: accept, latency, result/flags, optional backpressure, drain.
    task automatic do_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input bit s, input logic [31:0] er, input bit eo, input int hold);
        int n;
        out_ready = (hold == 0);
        n = 0;
        while (in_ready !== 1'b1 && n < 10) begin step(); n++; end
        check({tag, " in_ready_before"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; num1 = x; num2 = y; op_sub = s;
        step();
        // Garbage with in_valid high while busy must be ignored.
        num1 = $urandom; num2 = $urandom; op_sub = 1'($urandom_range(0, 1));
        check({tag, " in_ready_busy"}, 32'(in_ready), 32'd0);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin step(); n++; end
        in_valid = 1'b0;
        check({tag, " latency"}, 32'(n), 32'(NCH));
        check({tag, " s_res"}, s_res, er);
        check({tag, " ovf"}, 32'(ovf), 32'(eo));
        check({tag, " neg"}, 32'(neg), 32'(er[31]));
        check({tag, " zero"}, 32'(zero), 32'(er == 32'd0));
        check({tag, " in_ready_done"}, 32'(in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            step();
            check({tag, " hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold_s_res"}, s_res, er);
            check({tag, " hold_flags"}, {29'd0, ovf, neg, zero},
                  {29'd0, eo, er[31], er == 32'd0});
            check({tag, " hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        check({tag, " drained_valid"}, 32'(out_valid), 32'd0);
        check({tag, " idle_in_ready"}, 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] x, y, er;
        bit          s, eo;
        int          n;

        // Reset state.
        rst = 1'b1;
        step(); step();
        check("reset_outputs", {26'd0, in_ready, out_valid, ovf, neg, zero, |s_res}, 32'd0);
        rst = 1'b0;
        step();
        check("reset_in_ready_after", 32'(in_ready), 32'd1);

        // Directed cases.
        do_op("add_carry", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 0);
        do_op("sub_neg",   32'd3, 32'd10, 1'b1, 32'hFFFF_FFF9, 1'b0, 0);
        do_op("sub_zero",  32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b0, 0);
`ifdef SIGNED_ADDSUB_SAT_EN
        do_op("pos_ovf",   32'h7FFF_FFFF, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b1, 0);
        do_op("neg_ovf",   32'h8000_0000, 32'd1, 1'b1, 32'h8000_0000, 1'b1, 0);
        do_op("sub_min",   32'd0, 32'h8000_0000, 1'b1, 32'h7FFF_FFFF, 1'b1, 0);
`else
        do_op("pos_ovf",   32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b1, 0);
        do_op("neg_ovf",   32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 0);
        do_op("sub_min",   32'd0, 32'h8000_0000, 1'b1, 32'h8000_0000, 1'b1, 0);
`endif
        do_op("min_minus_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000, 1'b0, 0);
        do_op("backpressure",  32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFB, 1'b0, 5);

        // Reset in the second BUSY cycle abandons the operation.
        n = 0;
        while (in_ready !== 1'b1 && n < 10) begin step(); n++; end
        in_valid = 1'b1; num1 = 32'h1111_1111; num2 = 32'h2222_2222; op_sub = 1'b0;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("midbusy_reset_outputs",
              {26'd0, in_ready, out_valid, ovf, neg, zero, |s_res}, 32'd0);
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (out_valid !== 1'b0) n++;
        end
        check("midbusy_no_out_valid", 32'(n), 32'd0);
        check("midbusy_idle_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            x = pick();
            y = pick();
            s = 1'($urandom_range(0, 1));
            model(x, y, s, er, eo);
            do_op($sformatf("rand%0d", i), x, y, s, er, eo, int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
